count_key_sched: RTL and testbench

//  Sequences a saturating up/down event counter from two debounced push-keys.

---
 rtl/count_key_pkg.sv | 21 ++
 rtl/key_repeat.sv | 41 ++++
 rtl/count_key_sched.sv | 149 ++++++++++++++
 tb/tb_count_key_sched.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/count_key_pkg.sv
// Shared widths, state/grant encodings and the double-dabble nibble adjust
// for the key-driven counter and its BCD sequencer.
package count_key_pkg;

  localparam int CNT_W_DEF     = 10;
  localparam int MAX_COUNT_DEF = 1000;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} conv_state_t;
  typedef enum logic [1:0] {G_NONE, G_UP, G_DN} grant_t;

  // Add 3 to every BCD nibble >= 5 so the following left shift carries correctly.
  function automatic logic [15:0] dd_adjust(input logic [15:0] s);
    logic [15:0] r;
    r = s;
    for (int i = 0; i < 4; i++) begin
      if (s[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = s[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/key_repeat.sv
// Active-low key to request pulses: one on the press edge, then hold/auto-repeat
// timed by a single down-counter that is reloaded at each terminal count.
module key_repeat #(
  parameter int HOLD_CYC   = 25_000_000,
  parameter int REPEAT_CYC = 5_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic req
);

  localparam int HW = $clog2((HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC) + 1;

  logic          prev;
  logic [HW-1:0] hold_cnt;

  // The counter only runs while prev==0, which can only follow a detected press.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev     <= 1'b1;
      hold_cnt <= '0;
      req      <= 1'b0;
    end else begin
      prev <= key;
      req  <= 1'b0;
      if (key) begin
        hold_cnt <= '0;
      end else if (prev) begin
        req      <= 1'b1;
        hold_cnt <= HW'(HOLD_CYC - 1);
      end else if (hold_cnt == '0) begin
        req      <= 1'b1;
        hold_cnt <= HW'(REPEAT_CYC - 1);
      end else begin
        hold_cnt <= hold_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/count_key_sched.sv
// Saturating up/down counter shared by two key requesters with round-robin
// arbitration, plus a sequential double-dabble converter to four BCD digits.
//   state | meaning
//   IDLE  | outputs current, waiting for a count change
//   LOAD  | snapshot count, clear scratch
//   SHIFT | adjust + shift one bit per cycle, CNT_W cycles
//   DONE  | publish digits, pulse bcd_valid; restart if count moved meanwhile
module count_key_sched
  import count_key_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int MAX_COUNT  = MAX_COUNT_DEF,
  parameter int HOLD_CYC   = 25_000_000,
  parameter int REPEAT_CYC = 5_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_up,
  input  logic             key_dn,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic [3:0]       bcd0,
  output logic [3:0]       bcd1,
  output logic [3:0]       bcd2,
  output logic [3:0]       bcd3,
  output logic             bcd_valid,
  output logic             busy
);

  localparam int BW = $clog2(CNT_W + 1);

  logic req_up, req_dn;
  logic pend_up, pend_dn;
  logic rr_dn;
  logic cand_up, cand_dn;
  logic upd_up, upd_dn, upd;
  grant_t grant;

  conv_state_t      state;
  logic             dirty;
  logic [CNT_W-1:0] shreg;
  logic [15:0]      scratch;
  logic [15:0]      adj;
  logic [BW-1:0]    bit_cnt;

  key_repeat #(.HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC)) u_key_up (
    .clk(clk), .reset(reset), .key(key_up), .req(req_up)
  );

  key_repeat #(.HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC)) u_key_dn (
    .clk(clk), .reset(reset), .key(key_dn), .req(req_dn)
  );

  // A pending side always wins a collision; otherwise take the side rr did not last grant.
  always_comb begin
    cand_up = en & (pend_up | req_up);
    cand_dn = en & (pend_dn | req_dn);
    grant   = G_NONE;
    if (cand_up && cand_dn) begin
      if (pend_up)     grant = G_UP;
      else if (pend_dn) grant = G_DN;
      else if (rr_dn)   grant = G_UP;
      else              grant = G_DN;
    end else if (cand_up) begin
      grant = G_UP;
    end else if (cand_dn) begin
      grant = G_DN;
    end
    upd_up = (grant == G_UP) && (count != CNT_W'(MAX_COUNT));
    upd_dn = (grant == G_DN) && (count != '0);
    upd    = upd_up | upd_dn;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_up <= 1'b0;
      pend_dn <= 1'b0;
      rr_dn   <= 1'b0;
      count   <= '0;
    end else begin
      if (!en) begin
        pend_up <= 1'b0;
        pend_dn <= 1'b0;
      end else if (grant == G_UP) begin
        rr_dn   <= 1'b0;
        pend_up <= 1'b0;
        if (cand_dn) pend_dn <= 1'b1;
      end else if (grant == G_DN) begin
        rr_dn   <= 1'b1;
        pend_dn <= 1'b0;
        if (cand_up) pend_up <= 1'b1;
      end
      if (upd_up)      count <= count + 1'b1;
      else if (upd_dn) count <= count - 1'b1;
    end
  end

  assign adj  = dd_adjust(scratch);
  assign busy = (state == LOAD) || (state == SHIFT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      dirty     <= 1'b0;
      shreg     <= '0;
      scratch   <= '0;
      bit_cnt   <= '0;
      bcd0      <= '0;
      bcd1      <= '0;
      bcd2      <= '0;
      bcd3      <= '0;
      bcd_valid <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      if (upd && state != IDLE) dirty <= 1'b1;
      case (state)
        IDLE: if (upd) state <= LOAD;
        LOAD: begin
          shreg   <= count;
          scratch <= '0;
          bit_cnt <= BW'(CNT_W - 1);
          state   <= SHIFT;
        end
        SHIFT: begin
          scratch <= {adj[14:0], shreg[CNT_W-1]};
          shreg   <= {shreg[CNT_W-2:0], 1'b0};
          if (bit_cnt == '0) state <= DONE;
          else               bit_cnt <= bit_cnt - 1'b1;
        end
        DONE: begin
          bcd0      <= scratch[3:0];
          bcd1      <= scratch[7:4];
          bcd2      <= scratch[11:8];
          bcd3      <= scratch[15:12];
          bcd_valid <= 1'b1;
          // A change seen during this conversion (or right now) needs a fresh snapshot.
          if (dirty || upd) begin
            state <= LOAD;
            dirty <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_count_key_sched.sv
// Directed bench for count_key_sched with short hold/repeat timing.
module tb_count_key_sched;

  logic       clk = 1'b0;
  logic       reset, key_up, key_dn, en;
  logic [9:0] count;
  logic [3:0] bcd0, bcd1, bcd2, bcd3;
  logic       bcd_valid, busy;
  logic [15:0] bcd_all;

  int n_checks = 0;
  int n_pass   = 0;

  count_key_sched #(.CNT_W(10), .MAX_COUNT(1000), .HOLD_CYC(8), .REPEAT_CYC(4)) dut (
    .clk(clk), .reset(reset), .key_up(key_up), .key_dn(key_dn), .en(en),
    .count(count), .bcd0(bcd0), .bcd1(bcd1), .bcd2(bcd2), .bcd3(bcd3),
    .bcd_valid(bcd_valid), .busy(busy)
  );

  assign bcd_all = {bcd3, bcd2, bcd1, bcd0};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (bcd_valid) pulses++;
    end
  endtask

  task automatic press_up();
    key_up = 1'b0; tick(); key_up = 1'b1; tick(); tick();
  endtask

  task automatic press_dn();
    key_dn = 1'b0; tick(); key_dn = 1'b1; tick(); tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; key_up = 1'b1; key_dn = 1'b1; en = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    n_checks++;
    if (count !== 10'd0 || bcd_all !== 16'h0000 || bcd_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset: count=%0d bcd=%h valid=%b busy=%b, want 0/0000/0/0",
               count, bcd_all, bcd_valid, busy);
    else n_pass++;
  endtask

  task automatic test_press_latency();
    int n;
    for (int k = 1; k <= 3; k++) begin
      key_up = 1'b0; tick(); key_up = 1'b1; tick();
      n_checks++;
      if (count !== 10'(k) || busy !== 1'b1)
        $display("FAIL press%0d_count: count=%0d busy=%b, want %0d/1", k, count, busy, k);
      else n_pass++;
      n = 0;
      while (n < 30) begin
        tick(); n++;
        if (bcd_valid) break;
      end
      n_checks++;
      if (n !== 12) $display("FAIL press%0d_latency: got %0d cycles, want 12", k, n);
      else n_pass++;
    end
    n_checks++;
    if (bcd_all !== 16'h0003) $display("FAIL press_bcd: got %h, want 0003", bcd_all);
    else n_pass++;
  endtask

  task automatic test_saturation();
    int p;
    key_up = 1'b0;
    run(4100, p);
    key_up = 1'b1;
    run(40, p);
    n_checks++;
    if (count !== 10'd1000 || bcd_all !== 16'h1000)
      $display("FAIL sat_top_reach: count=%0d bcd=%h, want 1000/1000", count, bcd_all);
    else n_pass++;
    key_up = 1'b0; tick(); key_up = 1'b1;
    run(20, p);
    n_checks++;
    if (count !== 10'd1000 || p !== 0)
      $display("FAIL sat_top_hold: count=%0d pulses=%0d, want 1000/0", count, p);
    else n_pass++;
    key_dn = 1'b0;
    run(4100, p);
    key_dn = 1'b1;
    run(40, p);
    n_checks++;
    if (count !== 10'd0 || bcd_all !== 16'h0000)
      $display("FAIL sat_bot_reach: count=%0d bcd=%h, want 0/0000", count, bcd_all);
    else n_pass++;
    key_dn = 1'b0; tick(); key_dn = 1'b1;
    run(20, p);
    n_checks++;
    if (count !== 10'd0 || p !== 0)
      $display("FAIL sat_bot_hold: count=%0d pulses=%0d, want 0/0", count, p);
    else n_pass++;
  endtask

  task automatic test_auto_repeat();
    logic [31:0] mask;
    logic [9:0]  last;
    int p;
    mask = '0;
    last = count;
    key_up = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (count !== last) mask[k] = 1'b1;
      last = count;
    end
    key_up = 1'b1;
    run(40, p);
    n_checks++;
    if (mask !== 32'h4444_4404)
      $display("FAIL repeat_times: change mask=%h, want 44444404", mask);
    else n_pass++;
    n_checks++;
    if (count !== 10'd7 || bcd_all !== 16'h0007)
      $display("FAIL repeat_count: count=%0d bcd=%h, want 7/0007", count, bcd_all);
    else n_pass++;
  endtask

  task automatic test_arbitration();
    int p;
    press_dn(); press_dn(); press_dn(); press_up();
    run(30, p);
    n_checks++;
    if (count !== 10'd5) $display("FAIL arb_setup: count=%0d, want 5", count);
    else n_pass++;
    for (int r = 0; r < 2; r++) begin
      key_up = 1'b0; key_dn = 1'b0;
      tick();
      key_up = 1'b1; key_dn = 1'b1;
      tick();
      n_checks++;
      if (count !== 10'd4) $display("FAIL arb%0d_dn_first: count=%0d, want 4", r, count);
      else n_pass++;
      tick();
      n_checks++;
      if (count !== 10'd5) $display("FAIL arb%0d_up_next: count=%0d, want 5", r, count);
      else n_pass++;
      run(30, p);
    end
  endtask

  task automatic test_back_to_back();
    int pulses, t1, t2;
    logic [3:0] v1, v2;
    pulses = 0; t1 = -1; t2 = -1; v1 = 4'hf; v2 = 4'hf;
    key_up = 1'b0; tick(); key_up = 1'b1; tick();
    tick();
    key_up = 1'b0; tick(); key_up = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bcd_valid) begin
        pulses++;
        if (pulses == 1) begin t1 = i; v1 = bcd0; end
        if (pulses == 2) begin t2 = i; v2 = bcd0; end
      end
    end
    n_checks++;
    if (pulses !== 2) $display("FAIL b2b_pulses: got %0d, want 2", pulses);
    else n_pass++;
    n_checks++;
    if (v1 !== 4'd6 || v2 !== 4'd7)
      $display("FAIL b2b_values: got %0d,%0d, want 6,7", v1, v2);
    else n_pass++;
    n_checks++;
    if (t2 - t1 !== 12) $display("FAIL b2b_gap: got %0d, want 12", t2 - t1);
    else n_pass++;
    n_checks++;
    if (count !== 10'd7 || bcd_all !== 16'h0007)
      $display("FAIL b2b_final: count=%0d bcd=%h, want 7/0007", count, bcd_all);
    else n_pass++;
  endtask

  task automatic test_enable_and_reset();
    int p, q;
    en = 1'b0;
    press_up(); press_up(); press_dn();
    run(20, p);
    n_checks++;
    if (count !== 10'd7 || p !== 0)
      $display("FAIL en_off: count=%0d pulses=%0d, want 7/0", count, p);
    else n_pass++;
    en = 1'b1;
    tick();
    key_up = 1'b0; tick(); key_up = 1'b1; tick();
    tick(); tick(); tick();
    n_checks++;
    if (count !== 10'd8 || busy !== 1'b1)
      $display("FAIL mid_conv: count=%0d busy=%b, want 8/1", count, busy);
    else n_pass++;
    reset = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0 || count !== 10'd0 || bcd_all !== 16'h0000 || bcd_valid !== 1'b0)
      $display("FAIL abort: busy=%b count=%0d bcd=%h valid=%b, want 0/0/0000/0",
               busy, count, bcd_all, bcd_valid);
    else n_pass++;
    reset = 1'b0;
    run(20, q);
    n_checks++;
    if (q !== 0 || count !== 10'd0)
      $display("FAIL abort_quiet: pulses=%0d count=%0d, want 0/0", q, count);
    else n_pass++;
  endtask

  initial begin
    reset = 1'b1; key_up = 1'b1; key_dn = 1'b1; en = 1'b1;
    test_reset();
    test_press_latency();
    test_saturation();
    test_auto_repeat();
    test_arbitration();
    test_back_to_back();
    test_enable_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
